// File: rtl/storage_arbiter.sv
// storage_arbiter: round-robin arbiter that shares the single storage_controller port
// between the instruction-fetch and data requesters, one transaction outstanding at a time.
// Data writes at or above SRAM_LIMIT are rejected with an error response, and programming
// mode blocks new grants.
// Optional feature: define STORAGE_ARB_TIMEOUT_EN to build a read watchdog that ends a
// read with an error response after TIMEOUT_CYC cycles without mem_out_valid_i.
module storage_arbiter #(
  parameter int unsigned MEM_W       = 32,
  parameter logic [31:0] SRAM_LIMIT  = 32'h0000_2000,
  parameter int unsigned WR_LAT      = 1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // Instruction fetch requester (read only)
  input  logic               if_req_i,
  input  logic [31:0]        if_addr_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [MEM_W-1:0]   if_rdata_o,
  output logic               if_err_o,
  // Data requester
  input  logic               dt_req_i,
  input  logic               dt_we_i,
  input  logic [MEM_W/8-1:0] dt_be_i,
  input  logic [31:0]        dt_addr_i,
  input  logic [MEM_W-1:0]   dt_wdata_i,
  output logic               dt_gnt_o,
  output logic               dt_rvalid_o,
  output logic [MEM_W-1:0]   dt_rdata_o,
  output logic               dt_err_o,
  // Programming mode blocks new grants
  input  logic               prog_mode_i,
  // storage_controller port
  output logic               mem_access_o,
  output logic               mem_is_writing_o,
  output logic [31:0]        mem_addr_o,
  output logic [MEM_W-1:0]   mem_d_in_o,
  output logic [MEM_W/8-1:0] mem_be_o,
  input  logic [MEM_W-1:0]   mem_d_out_i,
  input  logic               mem_out_valid_i,
  output logic               busy_o
);

  localparam int unsigned BeW = MEM_W / 8;

`ifdef STORAGE_ARB_TIMEOUT_EN
  localparam int unsigned CntMax = (TIMEOUT_CYC > WR_LAT) ? TIMEOUT_CYC : WR_LAT;
`else
  localparam int unsigned CntMax = WR_LAT;
`endif
  localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] WrLast = CntW'(WR_LAT - 1);
`ifdef STORAGE_ARB_TIMEOUT_EN
  localparam logic [CntW-1:0] ToLast = CntW'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitRd,
    StWaitWr,
    StResp,
    StErr
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;  // 0: ifetch, 1: data
  logic             rr_q, rr_d;        // side that wins when both request
  logic             we_q, we_d;
  logic [BeW-1:0]   be_q, be_d;
  logic [31:0]      addr_q, addr_d;
  logic [MEM_W-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [MEM_W-1:0] if_rdata_q, if_rdata_d;
  logic [MEM_W-1:0] dt_rdata_q, dt_rdata_d;
  logic             pick_dt;
  logic             mem_drive;

  // Latched request stays on the memory port from ISSUE until the access completes
  assign mem_drive        = (state_q == StIssue) || (state_q == StWaitRd) ||
                            (state_q == StWaitWr);
  assign mem_access_o     = (state_q == StIssue);
  assign mem_is_writing_o = mem_drive & we_q;
  assign mem_addr_o       = mem_drive ? addr_q : '0;
  assign mem_d_in_o       = mem_drive ? wdata_q : '0;
  assign mem_be_o         = mem_drive ? be_q : '0;
  assign busy_o           = (state_q != StIdle);
  assign if_rdata_o       = if_rdata_q;
  assign dt_rdata_o       = dt_rdata_q;

  // Next-state, grant and response-pulse logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    dt_rdata_d  = dt_rdata_q;
    pick_dt     = 1'b0;
    if_gnt_o    = 1'b0;
    dt_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    dt_rvalid_o = 1'b0;
    if_err_o    = 1'b0;
    dt_err_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!prog_mode_i && (if_req_i || dt_req_i)) begin
          pick_dt = dt_req_i && (!if_req_i || rr_q);
          cnt_d   = '0;
          err_d   = 1'b0;
          if (pick_dt) begin
            dt_gnt_o = rst_ni;
            owner_d  = 1'b1;
            rr_d     = 1'b0;
            we_d     = dt_we_i;
            be_d     = dt_be_i;
            addr_d   = dt_addr_i;
            wdata_d  = dt_wdata_i;
            if (dt_we_i && (dt_addr_i >= SRAM_LIMIT)) begin
              // Out-of-window write never reaches the memory
              state_d    = StErr;
              dt_rdata_d = '0;
            end else begin
              state_d = StIssue;
            end
          end else begin
            if_gnt_o = rst_ni;
            owner_d  = 1'b0;
            rr_d     = 1'b1;
            we_d     = 1'b0;
            be_d     = '1;
            addr_d   = if_addr_i;
            wdata_d  = '0;
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = we_q ? StWaitWr : StWaitRd;
      end
      StWaitRd: begin
        if (mem_out_valid_i) begin
          state_d = StResp;
          err_d   = 1'b0;
          if (owner_q) dt_rdata_d = mem_d_out_i;
          else         if_rdata_d = mem_d_out_i;
        end
`ifdef STORAGE_ARB_TIMEOUT_EN
        else if (cnt_q == ToLast) begin
          state_d = StResp;
          err_d   = 1'b1;
          if (owner_q) dt_rdata_d = '0;
          else         if_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StWaitWr: begin
        // No downstream ack for writes: completion is purely time based
        if (cnt_q == WrLast) begin
          state_d = StResp;
          err_d   = 1'b0;
          if (owner_q) dt_rdata_d = '0;
          else         if_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (owner_q) begin
          dt_rvalid_o = 1'b1;
          dt_err_o    = err_q;
        end else begin
          if_rvalid_o = 1'b1;
          if_err_o    = err_q;
        end
        state_d = StIdle;
      end
      StErr: begin
        dt_rvalid_o = 1'b1;
        dt_err_o    = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dt_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dt_rdata_q <= dt_rdata_d;
    end
  end

endmodule
